move_controller: RTL and testbench

- Owns the authoritative 8x8 board register and turn state; downstream consumer of the possible-moves mask produced by the figure move-logic stage.
- Turns square clicks from the cursor/input stage into select / deselect / commit actions, and drives the selected piece code and position into the move-logic stage.
- Validates each destination against the returned mask, commits legal moves (including the castling rook move), toggles turn, and flags captures and game over.

---
 rtl/move_controller.sv | 263 ++++++++++++++++++++++++++
 tb/tb_move_controller.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_controller.sv
`timescale 1ns/1ps
// Chess move controller: owns the 8x8 board and turn, sequences select/validate/commit.
// Optional feature macro: AUTO_PROMOTION_EN (pawn reaching the last rank becomes a queen).
module move_controller #(
    parameter int MASK_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    new_game,
    input  logic                    click_valid,
    input  logic [5:0]              click_pos,
    input  logic [63:0]             possible_moves,
    output logic [3:0]              sel_figure,
    output logic [5:0]              sel_position,
    output logic [0:7][0:7][3:0]    board,
    output logic [63:0]             highlight,
    output logic                    turn,
    output logic                    move_done,
    output logic                    illegal,
    output logic [3:0]              captured,
    output logic                    game_over
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MASK_WAIT = 3'd1,
        S_SELECTED  = 3'd2,
        S_COMMIT    = 3'd3,
        S_CASTLE    = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    localparam logic [2:0] LAT_LOAD = 3'(MASK_LATENCY);

    function automatic logic [0:7][0:7][3:0] init_board();
        logic [0:7][0:7][3:0] b;
        b    = '0;
        b[0] = {4'hA, 4'h9, 4'h8, 4'hB, 4'hC, 4'h8, 4'h9, 4'hA};
        b[1] = {8{4'h7}};
        b[6] = {8{4'h1}};
        b[7] = {4'h4, 4'h3, 4'h2, 4'h5, 4'h6, 4'h2, 4'h3, 4'h4};
        return b;
    endfunction

    function automatic logic is_own(input logic [3:0] code, input logic side);
        if (side) begin
            return (code >= 4'd7) && (code <= 4'd12);
        end else begin
            return (code >= 4'd1) && (code <= 4'd6);
        end
    endfunction

    function automatic logic is_king(input logic [3:0] code);
        return (code == 4'd6) || (code == 4'd12);
    endfunction

    state_t               r_state, w_state_nxt;
    logic [2:0]           r_cnt, w_cnt_nxt;
    logic [5:0]           r_src_pos, w_src_pos_nxt;
    logic [5:0]           r_dst_pos, w_dst_pos_nxt;
    logic [3:0]           r_sel_figure, w_sel_figure_nxt;
    logic [0:7][0:7][3:0] r_board, w_board_nxt;
    logic [63:0]          r_highlight, w_highlight_nxt;
    logic                 r_turn, w_turn_nxt;
    logic                 r_move_done, w_move_done_nxt;
    logic                 r_illegal, w_illegal_nxt;
    logic [3:0]           r_captured, w_captured_nxt;
    logic                 r_game_over, w_game_over_nxt;

    logic [3:0]           w_click_fig;
    logic                 w_click_own;
    logic [3:0]           w_placed_fig;
    logic                 w_castle;

    assign w_click_fig = r_board[click_pos[5:3]][click_pos[2:0]];
    assign w_click_own = is_own(w_click_fig, r_turn);
    assign w_castle    = is_king(r_sel_figure) &&
                         (((r_src_pos == 6'd60) && ((r_dst_pos == 6'd62) || (r_dst_pos == 6'd58))) ||
                          ((r_src_pos == 6'd4)  && ((r_dst_pos == 6'd6)  || (r_dst_pos == 6'd2))));

`ifdef AUTO_PROMOTION_EN
    // Piece code actually placed on the destination square, with pawn promotion.
    always_comb begin
        w_placed_fig = r_sel_figure;
        if ((r_sel_figure == 4'd1) && (r_dst_pos[5:3] == 3'd0)) begin
            w_placed_fig = 4'd5;
        end else if ((r_sel_figure == 4'd7) && (r_dst_pos[5:3] == 3'd7)) begin
            w_placed_fig = 4'd11;
        end else begin
            w_placed_fig = r_sel_figure;
        end
    end
`else
    assign w_placed_fig = r_sel_figure;
`endif

    // Next-state and next-value logic for the whole controller.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_src_pos_nxt    = r_src_pos;
        w_dst_pos_nxt    = r_dst_pos;
        w_sel_figure_nxt = r_sel_figure;
        w_board_nxt      = r_board;
        w_highlight_nxt  = r_highlight;
        w_turn_nxt       = r_turn;
        w_move_done_nxt  = 1'b0;
        w_illegal_nxt    = 1'b0;
        w_captured_nxt   = r_captured;
        w_game_over_nxt  = r_game_over;
        case (r_state)
            S_IDLE: begin
                if (click_valid && !r_game_over && w_click_own) begin
                    w_src_pos_nxt    = click_pos;
                    w_sel_figure_nxt = w_click_fig;
                    w_cnt_nxt        = LAT_LOAD;
                    w_state_nxt      = S_MASK_WAIT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MASK_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_highlight_nxt = possible_moves;
                    w_state_nxt     = S_SELECTED;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            S_SELECTED: begin
                if (!click_valid) begin
                    w_state_nxt = S_SELECTED;
                end else if (click_pos == r_src_pos) begin
                    w_highlight_nxt  = 64'd0;
                    w_sel_figure_nxt = 4'd0;
                    w_state_nxt      = S_IDLE;
                end else if (w_click_own) begin
                    w_src_pos_nxt    = click_pos;
                    w_sel_figure_nxt = w_click_fig;
                    w_cnt_nxt        = LAT_LOAD;
                    w_state_nxt      = S_MASK_WAIT;
                end else if (r_highlight[click_pos]) begin
                    w_dst_pos_nxt = click_pos;
                    w_state_nxt   = S_COMMIT;
                end else begin
                    w_illegal_nxt = 1'b1;
                end
            end
            S_COMMIT: begin
                w_captured_nxt = r_board[r_dst_pos[5:3]][r_dst_pos[2:0]];
                w_board_nxt[r_dst_pos[5:3]][r_dst_pos[2:0]] = w_placed_fig;
                w_board_nxt[r_src_pos[5:3]][r_src_pos[2:0]] = 4'd0;
                if (w_castle) begin
                    w_state_nxt = S_CASTLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_CASTLE: begin
                // The king already sits on its destination; bring the matching rook across.
                case (r_dst_pos)
                    6'd62: begin
                        w_board_nxt[7][5] = r_board[7][7];
                        w_board_nxt[7][7] = 4'd0;
                    end
                    6'd58: begin
                        w_board_nxt[7][3] = r_board[7][0];
                        w_board_nxt[7][0] = 4'd0;
                    end
                    6'd6: begin
                        w_board_nxt[0][5] = r_board[0][7];
                        w_board_nxt[0][7] = 4'd0;
                    end
                    6'd2: begin
                        w_board_nxt[0][3] = r_board[0][0];
                        w_board_nxt[0][0] = 4'd0;
                    end
                    default: begin
                        w_board_nxt = r_board;
                    end
                endcase
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_move_done_nxt  = 1'b1;
                w_highlight_nxt  = 64'd0;
                w_sel_figure_nxt = 4'd0;
                if (is_king(r_captured)) begin
                    w_game_over_nxt = 1'b1;
                end else begin
                    w_turn_nxt = ~r_turn;
                end
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state register; new_game returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (new_game) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers: board, selection, turn and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= 3'd0;
            r_src_pos    <= 6'd0;
            r_dst_pos    <= 6'd0;
            r_sel_figure <= 4'd0;
            r_board      <= init_board();
            r_highlight  <= 64'd0;
            r_turn       <= 1'b0;
            r_move_done  <= 1'b0;
            r_illegal    <= 1'b0;
            r_captured   <= 4'd0;
            r_game_over  <= 1'b0;
        end else if (new_game) begin
            r_cnt        <= 3'd0;
            r_src_pos    <= 6'd0;
            r_dst_pos    <= 6'd0;
            r_sel_figure <= 4'd0;
            r_board      <= init_board();
            r_highlight  <= 64'd0;
            r_turn       <= 1'b0;
            r_move_done  <= 1'b0;
            r_illegal    <= 1'b0;
            r_captured   <= 4'd0;
            r_game_over  <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_src_pos    <= w_src_pos_nxt;
            r_dst_pos    <= w_dst_pos_nxt;
            r_sel_figure <= w_sel_figure_nxt;
            r_board      <= w_board_nxt;
            r_highlight  <= w_highlight_nxt;
            r_turn       <= w_turn_nxt;
            r_move_done  <= w_move_done_nxt;
            r_illegal    <= w_illegal_nxt;
            r_captured   <= w_captured_nxt;
            r_game_over  <= w_game_over_nxt;
        end
    end

    assign sel_figure   = r_sel_figure;
    assign sel_position = r_src_pos;
    assign board        = r_board;
    assign highlight    = r_highlight;
    assign turn         = r_turn;
    assign move_done    = r_move_done;
    assign illegal      = r_illegal;
    assign captured     = r_captured;
    assign game_over    = r_game_over;

endmodule

// File: tb/tb_move_controller.sv
`timescale 1ns/1ps
// Self-checking bench for move_controller against a square-array chess model.
module tb_move_controller;

    localparam int MASK_LAT = 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 new_game;
    logic                 click_valid;
    logic [5:0]           click_pos;
    logic [63:0]          possible_moves;
    logic [3:0]           sel_figure;
    logic [5:0]           sel_position;
    logic [0:7][0:7][3:0] board;
    logic [63:0]          highlight;
    logic                 turn;
    logic                 move_done;
    logic                 illegal;
    logic [3:0]           captured;
    logic                 game_over;

    int n_cmp = 0;
    int n_bad = 0;

    int m_board[64];
    bit m_turn;
    bit m_go;
    int m_cap;

    move_controller #(.MASK_LATENCY(MASK_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .new_game(new_game),
        .click_valid(click_valid), .click_pos(click_pos), .possible_moves(possible_moves),
        .sel_figure(sel_figure), .sel_position(sel_position), .board(board),
        .highlight(highlight), .turn(turn), .move_done(move_done), .illegal(illegal),
        .captured(captured), .game_over(game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic void model_init();
        int r0[8];
        int r7[8];
        r0 = '{10, 9, 8, 11, 12, 8, 9, 10};
        r7 = '{4, 3, 2, 5, 6, 2, 3, 4};
        for (int i = 0; i < 64; i++) m_board[i] = 0;
        for (int c = 0; c < 8; c++) begin
            m_board[c]      = r0[c];
            m_board[8 + c]  = 7;
            m_board[48 + c] = 1;
            m_board[56 + c] = r7[c];
        end
        m_turn = 1'b0;
        m_go   = 1'b0;
        m_cap  = 0;
    endfunction

    function automatic bit own(int code, bit side);
        return side ? (code >= 7 && code <= 12) : (code >= 1 && code <= 6);
    endfunction

    // Applies a move to the model; returns 1 when it was a castling move.
    function automatic bit model_move(int src, int dst);
        int fig;
        int placed;
        bit castle;
        fig    = m_board[src];
        m_cap  = m_board[dst];
        placed = fig;
`ifdef AUTO_PROMOTION_EN
        if (fig == 1 && dst / 8 == 0) placed = 5;
        if (fig == 7 && dst / 8 == 7) placed = 11;
`endif
        m_board[dst] = placed;
        m_board[src] = 0;
        castle = (fig == 6 || fig == 12) &&
                 ((src == 60 && (dst == 62 || dst == 58)) || (src == 4 && (dst == 6 || dst == 2)));
        if (castle) begin
            if (dst == 62) begin m_board[61] = m_board[63]; m_board[63] = 0; end
            if (dst == 58) begin m_board[59] = m_board[56]; m_board[56] = 0; end
            if (dst == 6)  begin m_board[5]  = m_board[7];  m_board[7]  = 0; end
            if (dst == 2)  begin m_board[3]  = m_board[0];  m_board[0]  = 0; end
        end
        if (m_cap == 6 || m_cap == 12) m_go = 1'b1;
        else m_turn = ~m_turn;
        return castle;
    endfunction

    function automatic int board_diff();
        for (int i = 0; i < 64; i++) begin
            if (board[i / 8][i % 8] !== 4'(m_board[i])) return i;
        end
        return -1;
    endfunction

    task automatic do_click(input int p);
        @(negedge clk);
        click_pos   = 6'(p);
        click_valid = 1'b1;
        @(negedge clk);
        click_valid = 1'b0;
    endtask

    task automatic select_sq(input int p, input logic [63:0] mask);
        possible_moves = mask;
        do_click(p);
        repeat (MASK_LAT + 2) @(negedge clk);
    endtask

    task automatic finish_move(input int dst, output int lat);
        do_click(dst);
        lat = 0;
        while (move_done !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 8) lat = -1;
    endtask

    task automatic pulse_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_init();
    endtask

    task automatic test_reset();
        int d;
        rst_n = 1'b0; new_game = 1'b0; click_valid = 1'b0; click_pos = 6'd0; possible_moves = 64'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_init();
        d = board_diff();
        n_cmp++; if (d !== -1) begin n_bad++; $display("FAIL reset_board: square %0d differs", d); end
        n_cmp++; if (board[7][4] !== 4'd6) begin n_bad++; $display("FAIL reset_wking: got %0d want 6", board[7][4]); end
        n_cmp++; if (board[0][4] !== 4'd12) begin n_bad++; $display("FAIL reset_bking: got %0d want 12", board[0][4]); end
        n_cmp++; if (board[3][3] !== 4'd0) begin n_bad++; $display("FAIL reset_empty: got %0d want 0", board[3][3]); end
        n_cmp++; if ({turn, move_done, illegal, game_over} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags: got %b want 0000", {turn, move_done, illegal, game_over}); end
        n_cmp++; if (sel_figure !== 4'd0 || highlight !== 64'd0 || captured !== 4'd0) begin
            n_bad++; $display("FAIL reset_sel: sel %0d hl %h cap %0d want 0", sel_figure, highlight, captured); end
    endtask

    task automatic test_illegal();
        logic [63:0] mask;
        mask = (64'd1 << 44) | (64'd1 << 36);
        select_sq(52, mask);
        n_cmp++; if (sel_figure !== 4'd1 || sel_position !== 6'd52) begin
            n_bad++; $display("FAIL sel_outputs: fig %0d pos %0d want 1/52", sel_figure, sel_position); end
        n_cmp++; if (highlight !== mask) begin n_bad++; $display("FAIL sel_highlight: got %h want %h", highlight, mask); end
        do_click(28);
        n_cmp++; if (illegal !== 1'b1) begin n_bad++; $display("FAIL illegal_pulse: got %b want 1", illegal); end
        @(negedge clk);
        n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL illegal_width: got %b want 0", illegal); end
        n_cmp++; if (board_diff() !== -1 || highlight !== mask) begin
            n_bad++; $display("FAIL illegal_hold: diff %0d hl %h want -1/%h", board_diff(), highlight, mask); end
        do_click(52);
        n_cmp++; if (highlight !== 64'd0 || sel_figure !== 4'd0) begin
            n_bad++; $display("FAIL deselect: hl %h fig %0d want 0/0", highlight, sel_figure); end
    endtask

    task automatic test_plain_move();
        int lat;
        select_sq(52, (64'd1 << 44) | (64'd1 << 36));
        finish_move(36, lat);
        void'(model_move(52, 36));
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL plain_latency: got %0d want 2", lat); end
        n_cmp++; if (board[4][4] !== 4'd1 || board[6][4] !== 4'd0) begin
            n_bad++; $display("FAIL plain_squares: got %0d/%0d want 1/0", board[4][4], board[6][4]); end
        n_cmp++; if (board_diff() !== -1) begin n_bad++; $display("FAIL plain_board: square %0d differs", board_diff()); end
        n_cmp++; if (turn !== 1'b1 || captured !== 4'd0) begin
            n_bad++; $display("FAIL plain_turn: turn %b cap %0d want 1/0", turn, captured); end
        @(negedge clk);
        n_cmp++; if (move_done !== 1'b0 || highlight !== 64'd0 || sel_figure !== 4'd0) begin
            n_bad++; $display("FAIL plain_after: done %b hl %h fig %0d want 0", move_done, highlight, sel_figure); end
    endtask

    task automatic test_wrong_turn();
        int seen;
        seen = 0;
        do_click(51);
        for (int i = 0; i < 5; i++) begin
            if (sel_figure !== 4'd0 || move_done !== 1'b0 || illegal !== 1'b0 || highlight !== 64'd0) seen++;
            @(negedge clk);
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL wrong_turn: %0d active cycles want 0", seen); end
        n_cmp++; if (turn !== 1'b1) begin n_bad++; $display("FAIL wrong_turn_turn: got %b want 1", turn); end
    endtask

    task automatic test_castle();
        int src_l[4];
        int dst_l[4];
        int lat;
        bit cst;
        src_l = '{61, 12, 62, 11};
        dst_l = '{44, 28, 45, 27};
        pulse_new_game();
        n_cmp++; if (board_diff() !== -1 || turn !== 1'b0) begin
            n_bad++; $display("FAIL new_game_reload: diff %0d turn %b", board_diff(), turn); end
        for (int k = 0; k < 4; k++) begin
            select_sq(src_l[k], 64'd1 << dst_l[k]);
            finish_move(dst_l[k], lat);
            void'(model_move(src_l[k], dst_l[k]));
            n_cmp++; if (lat !== 2 || board_diff() !== -1) begin
                n_bad++; $display("FAIL castle_prep%0d: lat %0d diff %0d want 2/-1", k, lat, board_diff()); end
        end
        select_sq(60, 64'd1 << 62);
        finish_move(62, lat);
        cst = model_move(60, 62);
        n_cmp++; if (lat !== (cst ? 3 : 2)) begin n_bad++; $display("FAIL castle_latency: got %0d want 3", lat); end
        n_cmp++; if ({board[7][4], board[7][5], board[7][6], board[7][7]} !== {4'd0, 4'd4, 4'd6, 4'd0}) begin
            n_bad++; $display("FAIL castle_squares: got %h want 0460", {board[7][4], board[7][5], board[7][6], board[7][7]}); end
        n_cmp++; if (board_diff() !== -1 || turn !== 1'b1) begin
            n_bad++; $display("FAIL castle_board: diff %0d turn %b", board_diff(), turn); end
    endtask

    task automatic test_promotion_game_over();
        int lat;
        int seen;
        int exp00;
`ifdef AUTO_PROMOTION_EN
        exp00 = 5;
`else
        exp00 = 1;
`endif
        pulse_new_game();
        select_sq(49, 64'd1 << 8);  finish_move(8, lat);  void'(model_move(49, 8));
        n_cmp++; if (captured !== 4'd7) begin n_bad++; $display("FAIL capture_pawn: got %0d want 7", captured); end
        select_sq(12, 64'd1 << 28); finish_move(28, lat); void'(model_move(12, 28));
        select_sq(8, 64'd1 << 0);   finish_move(0, lat);  void'(model_move(8, 0));
        n_cmp++; if (board[0][0] !== 4'(exp00)) begin n_bad++; $display("FAIL promotion: got %0d want %0d", board[0][0], exp00); end
        n_cmp++; if (captured !== 4'd10 || board_diff() !== -1) begin
            n_bad++; $display("FAIL promo_board: cap %0d diff %0d want 10/-1", captured, board_diff()); end
        select_sq(28, 64'd1 << 36); finish_move(36, lat); void'(model_move(28, 36));
        select_sq(0, 64'd1 << 4);   finish_move(4, lat);  void'(model_move(0, 4));
        n_cmp++; if (captured !== 4'd12 || game_over !== 1'b1) begin
            n_bad++; $display("FAIL king_capture: cap %0d go %b want 12/1", captured, game_over); end
        n_cmp++; if (turn !== m_turn || m_go !== 1'b1) begin n_bad++; $display("FAIL go_turn: got %b want %b", turn, m_turn); end
        seen = 0;
        possible_moves = 64'hFFFF_FFFF_FFFF_FFFF;
        do_click(48);
        for (int i = 0; i < 5; i++) begin
            if (sel_figure !== 4'd0 || move_done !== 1'b0 || illegal !== 1'b0) seen++;
            @(negedge clk);
        end
        n_cmp++; if (seen !== 0 || game_over !== 1'b1 || board_diff() !== -1) begin
            n_bad++; $display("FAIL go_ignore: active %0d go %b diff %0d", seen, game_over, board_diff()); end
    endtask

    task automatic test_random();
        int own_q[$];
        int dst_q[$];
        int src, dst, q, lat, s;
        bit cst;
        logic [63:0] mask;
        pulse_new_game();
        n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL go_clear: got %b want 0", game_over); end
        select_sq(52, 64'd1 << 36);
        pulse_new_game();
        n_cmp++; if (sel_figure !== 4'd0 || highlight !== 64'd0 || board_diff() !== -1) begin
            n_bad++; $display("FAIL midmove_reload: fig %0d hl %h diff %0d", sel_figure, highlight, board_diff()); end
        for (int n = 0; n < 30; n++) begin
            own_q.delete(); dst_q.delete();
            for (int i = 0; i < 64; i++) begin
                if (own(m_board[i], m_turn)) own_q.push_back(i);
                else if (m_board[i] != 6 && m_board[i] != 12) dst_q.push_back(i);
            end
            src  = own_q[$urandom_range(own_q.size() - 1, 0)];
            dst  = dst_q[$urandom_range(dst_q.size() - 1, 0)];
            mask = {$urandom, $urandom} | (64'd1 << dst);
            if (own_q.size() > 1 && $urandom_range(1, 0) == 1) begin
                q = own_q[$urandom_range(own_q.size() - 1, 0)];
                if (q != src) select_sq(q, mask);
            end
            select_sq(src, mask);
            n_cmp++; if (sel_position !== 6'(src) || sel_figure !== 4'(m_board[src]) || highlight !== mask) begin
                n_bad++; $display("FAIL rnd_select%0d: pos %0d fig %0d want %0d/%0d", n, sel_position, sel_figure, src, m_board[src]); end
            q = -1;
            s = $urandom_range(63, 0);
            for (int i = 0; i < 64; i++) begin
                if (q < 0 && !own(m_board[(s + i) % 64], m_turn) && mask[(s + i) % 64] == 1'b0) q = (s + i) % 64;
            end
            if (q >= 0 && $urandom_range(1, 0) == 1) begin
                do_click(q);
                n_cmp++; if (illegal !== 1'b1) begin n_bad++; $display("FAIL rnd_illegal%0d: sq %0d got %b want 1", n, q, illegal); end
            end
            finish_move(dst, lat);
            cst = model_move(src, dst);
            n_cmp++; if (lat !== (cst ? 3 : 2)) begin n_bad++; $display("FAIL rnd_latency%0d: got %0d want %0d", n, lat, cst ? 3 : 2); end
            n_cmp++; if (board_diff() !== -1) begin n_bad++; $display("FAIL rnd_board%0d: square %0d differs", n, board_diff()); end
            n_cmp++; if (turn !== m_turn || captured !== 4'(m_cap)) begin
                n_bad++; $display("FAIL rnd_state%0d: turn %b cap %0d want %b/%0d", n, turn, captured, m_turn, m_cap); end
        end
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_plain_move();
        test_wrong_turn();
        test_castle();
        test_promotion_game_over();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
